booth_mul_seq: RTL and testbench

BOOTH_MUL_SEQ -- requirements
Module: booth_mul_seq

---
 rtl/mul_pkg.sv | 15 +
 rtl/radix16_recoder.sv | 26 ++
 rtl/booth_mul_seq.sv | 122 ++++++++++++
 tb/tb_booth_mul_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential radix-16 Booth multiplier:
// FSM encoding, default digit counts and accumulator width.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIGITS_S_DEF = 8;
    localparam int DIGITS_U_DEF = 9;
    localparam int ACC_W        = 72;

endpackage

// File: rtl/radix16_recoder.sv
// Radix-16 Booth recoder: maps a 5-bit multiplier window to a signed digit
// in -8..+8, returned as sign plus magnitude.
module radix16_recoder
    import mul_pkg::*;
(
    input  logic [4:0] window,
    output logic       neg,
    output logic [3:0] mag
);

    logic [3:0] low_sum;

    // Digit value is -8*w4 + (4*w3 + 2*w2 + w1) + w0; low_sum is the
    // non-negative part, so the digit is low_sum or low_sum - 8.
    always_comb begin
        low_sum = {1'b0, window[3:1]} + {3'b000, window[0]};
        if (window[4]) begin
            mag = 4'd8 - low_sum;
            neg = (low_sum != 4'd8);
        end else begin
            mag = low_sum;
            neg = 1'b0;
        end
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential 32x32 multiplier (MULT/MULTU) retiring one radix-16 Booth
// digit per cycle into a 72-bit two's-complement accumulator.
module booth_mul_seq
    import mul_pkg::*;
#(
    parameter int DIGITS_S = DIGITS_S_DEF,
    parameter int DIGITS_U = DIGITS_U_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic        Signed,
    input  logic [31:0] Multiplicand,
    input  logic [31:0] Multiplier,
    output logic        Busy,
    output logic        Done,
    output logic [63:0] Product
);

    state_t state, state_next;

    logic signed [33:0]      mcand;
    logic [36:0]             mplier;
    logic                    op_signed;
    logic [3:0]              idx;
    logic [3:0]              last_idx;
    logic                    last_digit;
    logic [5:0]              shamt;
    logic [4:0]              window;
    logic                    neg;
    logic [3:0]              mag;
    logic signed [ACC_W-1:0] a_wide;
    logic signed [ACC_W-1:0] pp_mag;
    logic signed [ACC_W-1:0] pp;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = Start ? CALC : IDLE;
            CALC:    state_next = last_digit ? DONE : CALC;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Busy = (state == CALC) || (state == DONE);
        Done = (state == DONE);
    end

    assign last_idx   = op_signed ? 4'(DIGITS_S - 1) : 4'(DIGITS_U - 1);
    assign last_digit = (idx == last_idx);
    assign shamt      = {idx, 2'b00};
    assign window     = 5'(mplier >> shamt);

    radix16_recoder u_recoder (
        .window (window),
        .neg    (neg),
        .mag    (mag)
    );

    // x7 uses 8A - A so every multiple costs at most one adder.
    always_comb begin
        a_wide = {{(ACC_W-34){mcand[33]}}, mcand};
        case (mag)
            4'd1:    pp_mag = a_wide;
            4'd2:    pp_mag = a_wide <<< 1;
            4'd3:    pp_mag = (a_wide <<< 1) + a_wide;
            4'd4:    pp_mag = a_wide <<< 2;
            4'd5:    pp_mag = (a_wide <<< 2) + a_wide;
            4'd6:    pp_mag = (a_wide <<< 2) + (a_wide <<< 1);
            4'd7:    pp_mag = (a_wide <<< 3) - a_wide;
            4'd8:    pp_mag = a_wide <<< 3;
            default: pp_mag = '0;
        endcase
        pp       = neg ? -pp_mag : pp_mag;
        acc_next = acc + (pp <<< shamt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            idx       <= '0;
            Product   <= '0;
            mcand     <= '0;
            mplier    <= '0;
            op_signed <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        op_signed <= Signed;
                        mcand     <= {{2{Signed & Multiplicand[31]}}, Multiplicand};
                        mplier    <= {{4{Signed & Multiplier[31]}}, Multiplier, 1'b0};
                        acc       <= '0;
                        idx       <= '0;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    idx <= idx + 4'd1;
                    // Product only moves on the final digit so it is stable through CALC.
                    if (last_digit) begin
                        Product <= acc_next[63:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed corner cases, restart and
// reset behaviour, then randomized operations against a 64-bit reference.
module tb_booth_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic        Signed;
    logic [31:0] Multiplicand;
    logic [31:0] Multiplier;
    logic        Busy;
    logic        Done;
    logic [63:0] Product;

    int n_asserts = 0;
    int n_fail    = 0;

    booth_mul_seq dut (
        .clk          (clk),
        .reset        (reset),
        .Start        (Start),
        .Signed       (Signed),
        .Multiplicand (Multiplicand),
        .Multiplier   (Multiplier),
        .Busy         (Busy),
        .Done         (Done),
        .Product      (Product)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input bit sg, input logic [31:0] a, input logic [31:0] b);
        longint signed sa;
        longint signed sb;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'h0, a} * {32'h0, b};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts one operation in the next cycle (cycle 0) and follows it to Done.
    task automatic run_op(input bit sg, input logic [31:0] a, input logic [31:0] b,
                          input bit repulse, input string tag);
        logic [63:0] exp_p;
        logic [63:0] prev_p;
        int          lat;
        int          n;
        bit          seen;
        exp_p = ref_mul(sg, a, b);
        lat   = sg ? 9 : 10;
        @(posedge clk); #1;
        check({tag, "_idle_busy"}, {63'h0, Busy}, 64'h0);
        Signed       = sg;
        Multiplicand = a;
        Multiplier   = b;
        Start        = 1'b1;
        prev_p       = Product;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            Start        = repulse && (n == 4);
            Signed       = 1'($urandom);
            Multiplicand = $urandom;
            Multiplier   = $urandom;
            if (Done) begin
                seen = 1'b1;
            end else begin
                check({tag, "_calc_busy"}, {63'h0, Busy}, 64'h1);
                check({tag, "_calc_hold"}, Product, prev_p);
            end
        end
        Start = 1'b0;
        check({tag, "_latency"}, 64'(seen ? n : -1), 64'(lat));
        check({tag, "_product"}, Product, exp_p);
        check({tag, "_done_busy"}, {63'h0, Busy}, 64'h1);
    endtask

    initial begin
        int dones;
        reset        = 1'b1;
        Start        = 1'b0;
        Signed       = 1'b0;
        Multiplicand = 32'h0;
        Multiplier   = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'h0, Busy}, 64'h0);
        check("rst_done", {63'h0, Done}, 64'h0);
        check("rst_product", Product, 64'h0);
        reset = 1'b0;

        run_op(1'b1, 32'd3, 32'd5, 1'b0, "s_3x5");
        check("s_3x5_const", Product, 64'h0000_0000_0000_000F);
        run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "s_m1xm1");
        check("s_m1xm1_const", Product, 64'h0000_0000_0000_0001);
        run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, "s_minxmin");
        check("s_minxmin_const", Product, 64'h4000_0000_0000_0000);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "u_maxxmax");
        check("u_maxxmax_const", Product, 64'hFFFF_FFFE_0000_0001);
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "u_msb");
        run_op(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, "s_maxxmin");
        run_op(1'b1, 32'h0, 32'hDEAD_BEEF, 1'b0, "s_zero");

        // Start re-pulsed mid-operation must not restart or relatch.
        run_op(1'b1, 32'h1234_5678, 32'hFEDC_BA98, 1'b1, "s_repulse");
        dones = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (Done) dones++;
        end
        check("repulse_extra_done", 64'(dones), 64'h0);
        check("repulse_idle_busy", {63'h0, Busy}, 64'h0);

        // Reset during cycle 5 of a signed operation.
        @(posedge clk); #1;
        Signed       = 1'b1;
        Multiplicand = 32'h0BAD_F00D;
        Multiplier   = 32'h7654_3210;
        Start        = 1'b1;
        dones = 0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            Start = 1'b0;
            if (Done) dones++;
            if (c == 5) reset = 1'b1;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_busy", {63'h0, Busy}, 64'h0);
        check("midrst_done", {63'h0, Done}, 64'h0);
        check("midrst_product", Product, 64'h0);
        repeat (12) begin
            @(posedge clk); #1;
            if (Done) dones++;
        end
        check("midrst_no_done", 64'(dones), 64'h0);
        check("midrst_product_hold", Product, 64'h0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0013, 1'b0, "s_after_rst");

        for (int i = 0; i < 1000; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            bit          sg;
            int          gap;
            a  = $urandom;
            b  = $urandom;
            sg = 1'($urandom);
            case ($urandom_range(0, 7))
                0: a = 32'hFFFF_FFFF;
                1: b = 32'h8000_0000;
                2: a = 32'h8000_0000;
                default: ;
            endcase
            run_op(sg, a, b, 1'b0, sg ? "rnd_s" : "rnd_u");
            gap = $urandom_range(0, 3);
            // gap 0 leaves the next Start in the first IDLE cycle (back-to-back)
            if (gap > 1) repeat (gap - 1) @(posedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
